// File: rtl/rv32i_mem_responder_if.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rv32i_mem_responder_if
// Description : Single-port memory bus between the RV32I core and its responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface rv32i_mem_responder_if;
    logic [31:0] mem_addr;
    logic [31:0] mem_wr_data;
    logic        mem_wr_ena;
    logic [31:0] mem_rd_data;
    logic        core_ena;

    modport master (
        output mem_addr,
        output mem_wr_data,
        output mem_wr_ena,
        input  mem_rd_data,
        input  core_ena
    );

    modport slave (
        input  mem_addr,
        input  mem_wr_data,
        input  mem_wr_ena,
        output mem_rd_data,
        output core_ena
    );
endinterface
`default_nettype wire

// File: rtl/rv32i_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : rv32i_mem_responder
// Description : Word RAM plus MMIO page (LED, CYCLE, STATUS) behind the RV32I
//               core's memory port; stalls the core via core_ena on MMIO.
//               Optional macro RV32I_MEM_RESPONDER_BUS_ERR_EN enables the
//               sticky bus_err flag and the STATUS register.
// Revision    : 1.0 - initial release
// ============================================================================
module rv32i_mem_responder #(
    parameter int          RAM_WORDS = 1024,
    parameter              INIT_FILE = "",
    parameter int          MMIO_WAIT = 2,
    parameter logic [31:0] ERR_WORD  = 32'hDEAD_BEEF
) (
    input  wire                  clk,
    input  wire                  rst,
    rv32i_mem_responder_if.slave bus,
    output logic [15:0]          leds,
    output logic                 bus_err
);

    localparam int               c_AW        = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam logic [32:0]      c_RAM_LIMIT = 33'(RAM_WORDS) << 2;
    localparam int               c_WCW       = (MMIO_WAIT > 2) ? $clog2(MMIO_WAIT) : 1;
    localparam logic [c_WCW-1:0] c_WAIT_LOAD = (MMIO_WAIT > 0) ? c_WCW'(MMIO_WAIT - 1) : '0;
    localparam logic             c_STALL     = (MMIO_WAIT > 0);

    localparam logic [0:0] c_S_IDLE = 1'b0;
    localparam logic [0:0] c_S_WAIT = 1'b1;

    logic [0:0]       r_state;
    logic [0:0]       w_state_nxt;
    logic [c_WCW-1:0] r_wait_cnt;
    logic [c_WCW-1:0] w_cnt_nxt;
    logic             w_core_ena;

    logic [31:0]      r_ram [0:RAM_WORDS-1];
    logic [31:0]      r_rd_data;
    logic [15:0]      r_leds;
    logic [31:0]      r_cycle;
    logic [31:0]      w_rd_mux;

    logic             w_ram_hit;
    logic             w_mmio_page;
    logic             w_led_hit;
    logic             w_cycle_hit;
    logic             w_status_hit;
    logic             w_mmio_hit;
    logic             w_unmapped;
    logic             w_commit;
    logic             w_wr;
    logic [c_AW-1:0]  w_ram_idx;
    logic             w_unused;

    // Address decode; byte-lane bits are don't-care everywhere.
    assign w_ram_hit    = {1'b0, bus.mem_addr} < c_RAM_LIMIT;
    assign w_ram_idx    = bus.mem_addr[c_AW+1:2];
    assign w_mmio_page  = (bus.mem_addr[31:28] == 4'hF);
    assign w_led_hit    = w_mmio_page && (bus.mem_addr[27:2] == 26'd0);
    assign w_cycle_hit  = w_mmio_page && (bus.mem_addr[27:2] == 26'd1);
    assign w_mmio_hit   = w_led_hit || w_cycle_hit || w_status_hit;
    assign w_unmapped   = !w_ram_hit && !w_mmio_hit;
    assign w_unused     = ^bus.mem_addr[1:0];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_wait_cnt;
        w_core_ena  = 1'b1;
        case (r_state)
            c_S_IDLE: begin
                if (c_STALL && w_mmio_hit) begin
                    w_core_ena  = 1'b0;
                    w_cnt_nxt   = c_WAIT_LOAD;
                    w_state_nxt = c_S_WAIT;
                end
            end
            c_S_WAIT: begin
                if (r_wait_cnt != '0) begin
                    w_core_ena = 1'b0;
                    w_cnt_nxt  = r_wait_cnt - c_WCW'(1);
                end else begin
                    w_state_nxt = c_S_IDLE;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    // Reset suppresses any commit, so a stall interrupted by reset never lands.
    assign w_commit = w_core_ena && !rst;
    assign w_wr     = w_commit && bus.mem_wr_ena;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_rd_mux = ERR_WORD;
        if (w_ram_hit)         w_rd_mux = r_ram[w_ram_idx];
        else if (w_led_hit)    w_rd_mux = {16'b0, r_leds};
        else if (w_cycle_hit)  w_rd_mux = r_cycle;
        else if (w_status_hit) w_rd_mux = {31'b0, bus_err};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data <= '0;
            r_leds    <= '0;
            r_cycle   <= '0;
        end else begin
            if (w_commit)
                r_rd_data <= w_rd_mux;
            if (w_wr && w_led_hit)
                r_leds <= bus.mem_wr_data[15:0];
            if (w_wr && w_cycle_hit)
                r_cycle <= bus.mem_wr_data;
            else
                r_cycle <= r_cycle + 32'd1;
        end
    end

    // RAM has no reset; the read path above sees the pre-write contents.
    always_ff @(posedge clk) begin
        if (w_wr && w_ram_hit)
            r_ram[w_ram_idx] <= bus.mem_wr_data;
    end

`ifdef RV32I_MEM_RESPONDER_BUS_ERR_EN
    logic r_bus_err;

    assign w_status_hit = w_mmio_page && (bus.mem_addr[27:2] == 26'd2);

    // A new error outranks a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst)
            r_bus_err <= 1'b0;
        else if (w_commit && w_unmapped)
            r_bus_err <= 1'b1;
        else if (w_wr && w_status_hit && bus.mem_wr_data[0])
            r_bus_err <= 1'b0;
    end

    assign bus_err = r_bus_err;
`else
    assign w_status_hit = 1'b0;
    assign bus_err      = 1'b0;
`endif

    assign bus.mem_rd_data = r_rd_data;
    assign bus.core_ena    = w_core_ena;
    assign leds            = r_leds;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_mem_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_rv32i_mem_responder
// Description : Directed scoreboard bench for rv32i_mem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rv32i_mem_responder;

    localparam logic [31:0] LED_A  = 32'hF000_0000;
    localparam logic [31:0] CYC_A  = 32'hF000_0004;
    localparam logic [31:0] STAT_A = 32'hF000_0008;
    localparam logic [31:0] ERR    = 32'hDEAD_BEEF;
`ifdef RV32I_MEM_RESPONDER_BUS_ERR_EN
    localparam logic        BE_EN  = 1'b1;
`else
    localparam logic        BE_EN  = 1'b0;
`endif

    typedef struct {
        logic [31:0] e_data;
        bit          e_chk;
        string       e_name;
    } sb_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] leds;
    logic        bus_err;
    logic [15:0] leds_before;
    bit          drv_active = 1'b0;
    sb_t         sb_q[$];
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    rv32i_mem_responder_if bus_if();

    rv32i_mem_responder #(
        .RAM_WORDS (1024),
        .INIT_FILE (""),
        .MMIO_WAIT (2),
        .ERR_WORD  (32'hDEAD_BEEF)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus_if),
        .leds    (leds),
        .bus_err (bus_err)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one access and hold it until the DUT commits it.
    task automatic access(input string name, input logic [31:0] a, input logic [31:0] wd,
                          input logic we, input logic [31:0] exp, input bit chk, input int exp_stall);
        int stalls = 0;
        bit done = 1'b0;
        @(negedge clk);
        bus_if.mem_addr    = a;
        bus_if.mem_wr_data = wd;
        bus_if.mem_wr_ena  = we;
        drv_active         = 1'b1;
        sb_q.push_back('{e_data: exp, e_chk: chk, e_name: name});
        while (!done) begin
            #2;
            if (bus_if.core_ena) begin
                leds_before = leds;
                @(posedge clk);
                done = 1'b1;
            end else if (stalls >= 16) begin
                vectors++;
                miscompares++;
                $display("FAIL %s_timeout: got no commit after %0d cycles, required commit", name, stalls);
                void'(sb_q.pop_back());
                done = 1'b1;
            end else begin
                stalls++;
                @(negedge clk);
            end
        end
        #1;
        drv_active         = 1'b0;
        bus_if.mem_addr    = '0;
        bus_if.mem_wr_data = '0;
        bus_if.mem_wr_ena  = 1'b0;
        check({name, "_stall"}, 32'(stalls), 32'(exp_stall));
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus_if.mem_addr    = '0;
        bus_if.mem_wr_data = '0;
        bus_if.mem_wr_ena  = 1'b0;
        drv_active         = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: a commit seen before the edge yields read data after it.
    initial begin : monitor
        bit  pend;
        sb_t e;
        forever begin
            @(negedge clk);
            #2;
            pend = drv_active && bus_if.core_ena && !rst;
            @(posedge clk);
            #1;
            if (pend) begin
                if (sb_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL sb_empty: got commit with rd_data %h, required queued entry", bus_if.mem_rd_data);
                end else begin
                    e = sb_q.pop_front();
                    if (e.e_chk) check(e.e_name, bus_if.mem_rd_data, e.e_data);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no end of test, required finish");
        $fatal(1);
    end

    initial begin : stim
        bus_if.mem_addr    = '0;
        bus_if.mem_wr_data = '0;
        bus_if.mem_wr_ena  = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_rd_data", bus_if.mem_rd_data, 32'h0);
        check("rst_leds", {16'b0, leds}, 32'h0);
        check("rst_bus_err", {31'b0, bus_err}, 32'h0);
        check("rst_core_ena", {31'b0, bus_if.core_ena}, 32'h1);
        rst = 1'b0;

        // RAM write/read and region boundary
        access("ram_wr10", 32'h10, 32'h1234_5678, 1'b1, 32'h0, 1'b0, 0);
        access("ram_rd10", 32'h10, 32'h0, 1'b0, 32'h1234_5678, 1'b1, 0);
        access("ram_wr_last", 32'hFFC, 32'hCAFE_F00D, 1'b1, 32'h0, 1'b0, 0);
        access("ram_rd_last", 32'hFFC, 32'h0, 1'b0, 32'hCAFE_F00D, 1'b1, 0);

        // LED write with stall
        access("led_wr", LED_A, 32'hFFFF_A5A5, 1'b1, 32'h0, 1'b1, 2);
        check("led_before", {16'b0, leds_before}, 32'h0);
        check("led_after", {16'b0, leds}, 32'h0000_A5A5);
        access("led_rd", LED_A, 32'h0, 1'b0, 32'h0000_A5A5, 1'b1, 2);

        // Cycle counter wraps: FFFFFFFE then 5 more edges before capture
        access("cyc_wr", CYC_A, 32'hFFFF_FFFE, 1'b1, 32'h0, 1'b0, 2);
        idle(3);
        access("cyc_rd", CYC_A, 32'h0, 1'b0, 32'h0000_0003, 1'b1, 2);

        // Unmapped accesses and STATUS
        access("ram_past_end", 32'h1000, 32'h0, 1'b0, ERR, 1'b1, 0);
        access("unmap_rd", 32'h8000_0000, 32'h0, 1'b0, ERR, 1'b1, 0);
        check("bus_err_set", {31'b0, bus_err}, {31'b0, BE_EN});
        if (BE_EN) begin
            access("stat_clr", STAT_A, 32'h1, 1'b1, 32'h1, 1'b1, 2);
            check("bus_err_clr", {31'b0, bus_err}, 32'h0);
            access("stat_rd", STAT_A, 32'h0, 1'b0, 32'h0, 1'b1, 2);
        end else begin
            access("stat_clr", STAT_A, 32'h1, 1'b1, ERR, 1'b1, 0);
            check("bus_err_clr", {31'b0, bus_err}, 32'h0);
            access("stat_rd", STAT_A, 32'h0, 1'b0, ERR, 1'b1, 0);
        end
        access("mmio_hole", 32'hF000_000C, 32'h0, 1'b0, ERR, 1'b1, 0);
        check("bus_err_hole", {31'b0, bus_err}, {31'b0, BE_EN});

        // Reset during the second WAIT cycle of an LED write
        @(negedge clk);
        bus_if.mem_addr    = LED_A;
        bus_if.mem_wr_data = 32'h0000_00FF;
        bus_if.mem_wr_ena  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("rst_wait_core_ena", {31'b0, bus_if.core_ena}, 32'h1);
        @(posedge clk);
        #1;
        check("rst_mid_leds", {16'b0, leds}, 32'h0);
        check("rst_mid_bus_err", {31'b0, bus_err}, 32'h0);
        check("rst_mid_rd_data", bus_if.mem_rd_data, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        bus_if.mem_wr_ena = 1'b0;
        #2;
        check("rst_mid_idle_stall", {31'b0, bus_if.core_ena}, 32'h0);
        idle(4);
        access("led_post_rst", LED_A, 32'h0, 1'b0, 32'h0, 1'b1, 2);

        // Read-before-write on the same RAM word
        access("rbw_init", 32'h20, 32'h7, 1'b1, 32'h0, 1'b0, 0);
        access("rbw_wr", 32'h20, 32'h9, 1'b1, 32'h7, 1'b1, 0);
        access("rbw_rd", 32'h20, 32'h0, 1'b0, 32'h9, 1'b1, 0);

        idle(2);
        check("sb_drain", 32'(sb_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
